// File: rtl/argmax_pkg.sv
// Shared types and helpers for the top-2 argmax scanner: FSM encoding,
// the per-configuration minimum value and the "beats" ordering.
package argmax_pkg;

  // Widest score word the helpers handle; callers widen into and narrow out of this.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Smallest representable score: 100..0 when signed, all zeros when unsigned.
  function automatic logic [MAX_W-1:0] minv(input int data_w, input bit signed_cmp);
    logic [MAX_W-1:0] m;
    m = '0;
    if (signed_cmp) m[data_w-1] = 1'b1;
    return m;
  endfunction

  // Operands must already be sign- or zero-extended to MAX_W to match signed_cmp.
  function automatic logic beats(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b,
                                 input bit signed_cmp, input bit tie_last);
    logic gt;
    gt = signed_cmp ? ($signed(a) > $signed(b)) : (a > b);
    return gt || (tie_last && (a == b));
  endfunction

endpackage

// File: rtl/argmax_top2_update.sv
// Combinational next state of the {best, second} pairs after one sample.
// Kept standalone so a multi-lane variant can chain several of these.
module argmax_top2_update
  import argmax_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int SIGNED_CMP = 1,
  parameter int TIE_LAST   = 0
) (
  input  logic              vld,
  input  logic [DATA_W-1:0] val,
  input  logic [ADDR_W-1:0] idx,
  input  logic              best_ok,
  input  logic [DATA_W-1:0] best_val,
  input  logic [ADDR_W-1:0] best_idx,
  input  logic              sec_ok,
  input  logic [DATA_W-1:0] sec_val,
  input  logic [ADDR_W-1:0] sec_idx,
  output logic              nxt_best_ok,
  output logic [DATA_W-1:0] nxt_best_val,
  output logic [ADDR_W-1:0] nxt_best_idx,
  output logic              nxt_sec_ok,
  output logic [DATA_W-1:0] nxt_sec_val,
  output logic [ADDR_W-1:0] nxt_sec_idx
);

  function automatic logic [MAX_W-1:0] widen(input logic [DATA_W-1:0] x);
    if (SIGNED_CMP != 0) return MAX_W'($signed(x));
    return MAX_W'(x);
  endfunction

  logic win_best;
  logic win_sec;

  always_comb begin
    // NOTE: every output gets its hold value first, so no path can infer a latch.
    nxt_best_ok  = best_ok;
    nxt_best_val = best_val;
    nxt_best_idx = best_idx;
    nxt_sec_ok   = sec_ok;
    nxt_sec_val  = sec_val;
    nxt_sec_idx  = sec_idx;
    win_best = beats(widen(val), widen(best_val), SIGNED_CMP != 0, TIE_LAST != 0);
    win_sec  = beats(widen(val), widen(sec_val), SIGNED_CMP != 0, TIE_LAST != 0);
    // Valid flags, not the value compare, admit the first samples (MINV is a real score).
    if (vld) begin
      if (!best_ok || win_best) begin
        nxt_sec_ok   = best_ok;
        nxt_sec_val  = best_val;
        nxt_sec_idx  = best_idx;
        nxt_best_ok  = 1'b1;
        nxt_best_val = val;
        nxt_best_idx = idx;
      end else if (!sec_ok || win_sec) begin
        nxt_sec_ok  = 1'b1;
        nxt_sec_val = val;
        nxt_sec_idx = idx;
      end
    end
  end

endmodule

// File: rtl/argmax_top2_stream.sv
// Scans a synchronous-read score memory and reports the best and runner-up
// index/value pairs through a start/busy/done handshake.
module argmax_top2_stream
  import argmax_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int RD_LAT     = 1,
  parameter int SIGNED_CMP = 1,
  parameter int TIE_LAST   = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W:0]   size,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              empty,
  output logic [ADDR_W-1:0] best_idx,
  output logic [DATA_W-1:0] best_val,
  output logic [ADDR_W-1:0] second_idx,
  output logic [DATA_W-1:0] second_val,
  output logic              second_vld
);

  localparam logic [MAX_W-1:0]  MINV_X = minv(DATA_W, SIGNED_CMP != 0);
  localparam logic [DATA_W-1:0] MINV   = MINV_X[DATA_W-1:0];
  localparam logic [ADDR_W:0]   DEPTH  = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  logic [ADDR_W:0]   size_q;
  logic [ADDR_W:0]   size_c;

  logic [RD_LAT-1:0] tag_vld;
  logic [ADDR_W-1:0] tag_idx   [RD_LAT];
  logic [RD_LAT:0]   vld_chain;
  logic [ADDR_W-1:0] idx_chain [RD_LAT+1];

  logic              cur_b_ok, cur_s_ok, nxt_b_ok, nxt_s_ok;
  logic [DATA_W-1:0] cur_b_val, cur_s_val, nxt_b_val, nxt_s_val;
  logic [ADDR_W-1:0] cur_b_idx, cur_s_idx, nxt_b_idx, nxt_s_idx;

  assign size_c    = (size > DEPTH) ? DEPTH : size;
  assign busy      = (state != IDLE);
  assign vld_chain = {tag_vld, rd_en};

  always_comb begin
    idx_chain[0] = rd_addr;
    for (int i = 0; i < RD_LAT; i++) idx_chain[i+1] = tag_idx[i];
  end

  // Tag stage RD_LAT-1 lines up with the word arriving on rd_data this cycle.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: tags carry an async reset so a mid-scan reset flushes in-flight returns.
    if (!resetn) begin
      tag_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_idx[i] <= '0;
    end else begin
      tag_vld <= vld_chain[RD_LAT-1:0];
      for (int i = 0; i < RD_LAT; i++) tag_idx[i] <= idx_chain[i];
    end
  end

  argmax_top2_update #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .SIGNED_CMP(SIGNED_CMP),
    .TIE_LAST  (TIE_LAST)
  ) u_update (
    .vld         (tag_vld[RD_LAT-1]),
    .val         (rd_data),
    .idx         (tag_idx[RD_LAT-1]),
    .best_ok     (cur_b_ok),
    .best_val    (cur_b_val),
    .best_idx    (cur_b_idx),
    .sec_ok      (cur_s_ok),
    .sec_val     (cur_s_val),
    .sec_idx     (cur_s_idx),
    .nxt_best_ok (nxt_b_ok),
    .nxt_best_val(nxt_b_val),
    .nxt_best_idx(nxt_b_idx),
    .nxt_sec_ok  (nxt_s_ok),
    .nxt_sec_val (nxt_s_val),
    .nxt_sec_idx (nxt_s_idx)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      size_q     <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      done       <= 1'b0;
      empty      <= 1'b0;
      cur_b_ok   <= 1'b0;
      cur_b_val  <= MINV;
      cur_b_idx  <= '0;
      cur_s_ok   <= 1'b0;
      cur_s_val  <= MINV;
      cur_s_idx  <= '0;
      best_idx   <= '0;
      best_val   <= MINV;
      second_idx <= '0;
      second_val <= MINV;
      second_vld <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; the later clear in IDLE overrides this default update.
      done      <= 1'b0;
      cur_b_ok  <= nxt_b_ok;
      cur_b_val <= nxt_b_val;
      cur_b_idx <= nxt_b_idx;
      cur_s_ok  <= nxt_s_ok;
      cur_s_val <= nxt_s_val;
      cur_s_idx <= nxt_s_idx;
      case (state)
        IDLE: if (start) begin
          size_q    <= size_c;
          empty     <= 1'b0;
          cur_b_ok  <= 1'b0;
          cur_b_val <= MINV;
          cur_b_idx <= '0;
          cur_s_ok  <= 1'b0;
          cur_s_val <= MINV;
          cur_s_idx <= '0;
          // An empty scan passes through DRAIN for one cycle so done lands in cycle 2.
          if (size_c != '0) begin
            state   <= ISSUE;
            rd_en   <= 1'b1;
            rd_addr <= '0;
          end else begin
            state <= DRAIN;
          end
        end
        ISSUE: begin
          if ({1'b0, rd_addr} == size_q - 1'b1) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
            state   <= DRAIN;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        DRAIN: if (tag_vld == '0) begin
          state      <= DONE;
          done       <= 1'b1;
          empty      <= (size_q == '0);
          best_idx   <= cur_b_idx;
          best_val   <= cur_b_val;
          second_idx <= cur_s_idx;
          second_val <= cur_s_val;
          second_vld <= cur_s_ok;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_top2_stream.sv
// Directed bench: four scanner configurations share one score memory and stimulus.
module tb_argmax_top2_stream;

  function automatic int lat_of(input int g);
    case (g)
      0, 1:    return 1;
      2:       return 3;
      default: return 2;
    endcase
  endfunction
  function automatic int sgn_of(input int g); return (g == 3) ? 0 : 1; endfunction
  function automatic int tie_of(input int g); return (g == 1) ? 1 : 0; endfunction
  function automatic logic [31:0] minv_of(input int g);
    return (sgn_of(g) != 0) ? 32'h8000_0000 : 32'h0;
  endfunction

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [4:0]  size;
  logic        clr;
  logic [31:0] mem [16];
  int          cyc = 0;
  int          base = 0;
  int          n_chk = 0;
  int          n_err = 0;

  logic [3:0]  rd_en, busy, done, empty, second_vld;
  logic [3:0]  rd_addr [4];
  logic [3:0]  best_idx [4];
  logic [3:0]  second_idx [4];
  logic [31:0] rd_data [4];
  logic [31:0] best_val [4];
  logic [31:0] second_val [4];
  int          dcyc_a [4];
  int          dcnt_a [4];
  int          rcnt_a [4];
  int          abad_a [4];

  always #5 clk = ~clk;
  always_ff @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : u
    localparam int LAT = lat_of(g);
    logic [31:0] pipe [LAT];
    int dcyc, dcnt, rcnt, abad, nexp;

    argmax_top2_stream #(
      .DATA_W(32), .ADDR_W(4), .RD_LAT(LAT), .SIGNED_CMP(sgn_of(g)), .TIE_LAST(tie_of(g))
    ) dut (
      .clk(clk), .resetn(resetn), .start(start), .size(size),
      .rd_en(rd_en[g]), .rd_addr(rd_addr[g]), .rd_data(rd_data[g]),
      .busy(busy[g]), .done(done[g]), .empty(empty[g]),
      .best_idx(best_idx[g]), .best_val(best_val[g]),
      .second_idx(second_idx[g]), .second_val(second_val[g]), .second_vld(second_vld[g])
    );

    // Synchronous-read memory; junk on cycles with no read in flight.
    always_ff @(posedge clk) begin
      pipe[0] <= rd_en[g] ? mem[rd_addr[g]] : 32'hDEAD_BEEF;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign rd_data[g] = pipe[LAT-1];

    always_ff @(negedge clk) begin
      if (clr) begin
        dcyc <= -1; dcnt <= 0; rcnt <= 0; abad <= 0; nexp <= 0;
      end else begin
        if (done[g]) begin
          dcyc <= cyc - base;
          dcnt <= dcnt + 1;
        end
        if (rd_en[g]) begin
          rcnt <= rcnt + 1;
          nexp <= nexp + 1;
          if (rd_addr[g] != nexp[3:0]) abad <= abad + 1;
        end
      end
    end
    assign dcyc_a[g] = dcyc;
    assign dcnt_a[g] = dcnt;
    assign rcnt_a[g] = rcnt;
    assign abad_a[g] = abad;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Start is sampled at the edge ending cycle 0; returns #1 into cycle 1.
  task automatic start_scan(input logic [4:0] sz);
    @(posedge clk); #1 clr = 1'b1;
    @(negedge clk); #1 clr = 1'b0;
    size = sz; start = 1'b1;
    @(posedge clk); #1 base = cyc - 1; start = 1'b0;
  endtask

  task automatic settle();
    repeat (40) @(negedge clk);
  endtask

  task automatic expect_res(input int t, input int g, input int sz, input logic [3:0] bi,
                            input logic [31:0] bv, input logic [3:0] si, input logic [31:0] sv,
                            input logic svld, input logic emp);
    string p;
    int nrd;
    p = $sformatf("t%0d.u%0d", t, g);
    nrd = (sz > 16) ? 16 : sz;
    check({p, ".done_cyc"}, dcyc_a[g], (nrd == 0) ? 2 : nrd + lat_of(g) + 2);
    check({p, ".done_cnt"}, dcnt_a[g], 1);
    check({p, ".reads"}, rcnt_a[g], nrd);
    check({p, ".addr_seq"}, abad_a[g], 0);
    check({p, ".best_idx"}, best_idx[g], bi);
    check({p, ".best_val"}, best_val[g], bv);
    check({p, ".second_idx"}, second_idx[g], si);
    check({p, ".second_val"}, second_val[g], sv);
    check({p, ".second_vld"}, second_vld[g], svld);
    check({p, ".empty"}, empty[g], emp);
    check({p, ".busy"}, busy[g], 1'b0);
  endtask

  task automatic check_reset(input int t);
    string p;
    for (int g = 0; g < 4; g++) begin
      p = $sformatf("rst%0d.u%0d", t, g);
      check({p, ".busy"}, busy[g], 1'b0);
      check({p, ".done"}, done[g], 1'b0);
      check({p, ".rd_en"}, rd_en[g], 1'b0);
      check({p, ".rd_addr"}, rd_addr[g], 4'd0);
      check({p, ".empty"}, empty[g], 1'b0);
      check({p, ".second_vld"}, second_vld[g], 1'b0);
      check({p, ".best_idx"}, best_idx[g], 4'd0);
      check({p, ".best_val"}, best_val[g], minv_of(g));
      check({p, ".second_idx"}, second_idx[g], 4'd0);
      check({p, ".second_val"}, second_val[g], minv_of(g));
    end
  endtask

  task automatic load_a();
    logic [31:0] a [10];
    a = '{32'd3, -32'sd7, 32'd12, 32'd5, 32'd12, 32'd0, 32'd1, -32'sd2, 32'd9, 32'd4};
    for (int i = 0; i < 16; i++) mem[i] = (i < 10) ? a[i] : 32'h0;
  endtask

  task automatic load_b();
    mem[0] = 32'h8000_0000; mem[1] = 32'h7FFF_FFFF; mem[2] = 32'h1;
  endtask

  task automatic expect_a(input int t);
    expect_res(t, 0, 10, 4'd2, 32'd12, 4'd4, 32'd12, 1'b1, 1'b0);
    expect_res(t, 1, 10, 4'd4, 32'd12, 4'd2, 32'd12, 1'b1, 1'b0);
    expect_res(t, 2, 10, 4'd2, 32'd12, 4'd4, 32'd12, 1'b1, 1'b0);
    expect_res(t, 3, 10, 4'd7, 32'hFFFF_FFFE, 4'd1, 32'hFFFF_FFF9, 1'b1, 1'b0);
  endtask

  task automatic expect_b(input int t);
    for (int g = 0; g < 3; g++)
      expect_res(t, g, 3, 4'd1, 32'h7FFF_FFFF, 4'd2, 32'h1, 1'b1, 1'b0);
    expect_res(t, 3, 3, 4'd0, 32'h8000_0000, 4'd1, 32'h7FFF_FFFF, 1'b1, 1'b0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; start = 1'b0; size = '0; clr = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1 check_reset(0);
    @(negedge clk) resetn = 1'b1;

    // Mixed-sign data with a tie on the maximum.
    load_a();
    start_scan(5'd10); settle();
    expect_a(1);

    // Empty scan, then a single entry equal to MINV (signed).
    start_scan(5'd0); settle();
    for (int g = 0; g < 4; g++)
      expect_res(2, g, 0, 4'd0, minv_of(g), 4'd0, minv_of(g), 1'b0, 1'b1);
    mem[0] = 32'h8000_0000;
    start_scan(5'd1); settle();
    for (int g = 0; g < 4; g++)
      expect_res(3, g, 1, 4'd0, 32'h8000_0000, 4'd0, minv_of(g), 1'b0, 1'b0);

    // Signed vs unsigned ordering of the extremes.
    load_b();
    start_scan(5'd3); settle();
    expect_b(4);

    // Full depth, descending, then an oversize request clamped to full depth.
    for (int i = 0; i < 16; i++) mem[i] = 32'(15 - i);
    for (int r = 0; r < 2; r++) begin
      start_scan((r == 0) ? 5'd16 : 5'd31); settle();
      for (int g = 0; g < 4; g++)
        expect_res(5 + r, g, (r == 0) ? 16 : 31, 4'd0, 32'd15, 4'd1, 32'd14, 1'b1, 1'b0);
    end

    // A start pulse in cycle 4 of a running scan must not restart it.
    load_a();
    start_scan(5'd10);
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    settle();
    expect_a(7);

    // Asynchronous reset in cycle 6 of a scan, then a clean scan afterwards.
    start_scan(5'd10);
    repeat (5) @(posedge clk);
    #1 resetn = 1'b0;
    #1 check_reset(8);
    @(negedge clk) resetn = 1'b1;
    load_b();
    start_scan(5'd3); settle();
    expect_b(9);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
